// File: rtl/pe_group_acc.sv
// pe_group_acc: TAPS-wide signed dot-product PE that accumulates beats into per-group partial sums.
// Optional `PE_RELU_EN clamps negative group sums to zero on psum_out (accumulator stays signed).
//
// state | meaning
// IDLE  | no outstanding activity
// BUSY  | beats in flight or a group is still open
// DONE  | pipeline drained; finish_wb asserted for this single cycle
module pe_group_acc #(
  parameter int DW    = 8,
  parameter int TAPS  = 5,
  parameter int ACC_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [TAPS*DW-1:0]   weight_in,
  input  logic [TAPS*DW-1:0]   ifmap_in,
  output logic [ACC_W-1:0]     psum_out,
  output logic                 wb_en,
  output logic                 finish_wb,
  output logic                 seq_err
);

  localparam int PW    = 2 * DW;
  localparam int SUM_W = PW + $clog2(TAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                    open_grp;
  logic                    beat_first;
  logic                    accept;

  logic signed [PW-1:0]    prod_c [TAPS];
  logic signed [PW-1:0]    prod1  [TAPS];
  logic                    v1, f1, l1;

  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] sum2;
  logic                    v2, f2, l2;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic        [ACC_W-1:0] psum_c;

  assign accept = in_valid && !flush;
  // A beat arriving outside an open group restarts accumulation even without in_first.
  assign beat_first = in_first || !open_grp;

  // Input-side group tracking and sticky sequence error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      open_grp <= 1'b0;
      seq_err  <= 1'b0;
    end else if (flush) begin
      open_grp <= 1'b0;
      seq_err  <= 1'b0;
    end else if (in_valid) begin
      open_grp <= !in_last;
      if (!in_first && !open_grp) begin
        seq_err <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      prod_c[i] = PW'($signed(weight_in[i*DW +: DW])) * PW'($signed(ifmap_in[i*DW +: DW]));
    end
  end

  // S1: per-tap products
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      f1 <= 1'b0;
      l1 <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        prod1[i] <= '0;
      end
    end else if (flush) begin
      v1 <= 1'b0;
      f1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      v1 <= accept;
      f1 <= accept && beat_first;
      l1 <= accept && in_last;
      if (accept) begin
        for (int i = 0; i < TAPS; i++) begin
          prod1[i] <= prod_c[i];
        end
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum_c = sum_c + SUM_W'(prod1[i]);
    end
  end

  // S2: adder tree result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2   <= 1'b0;
      f2   <= 1'b0;
      l2   <= 1'b0;
      sum2 <= '0;
    end else if (flush) begin
      v2 <= 1'b0;
      f2 <= 1'b0;
      l2 <= 1'b0;
    end else begin
      v2 <= v1;
      f2 <= f1;
      l2 <= l1;
      if (v1) begin
        sum2 <= sum_c;
      end
    end
  end

  assign acc_nxt = f2 ? ACC_W'(sum2) : acc + ACC_W'(sum2);

`ifdef PE_RELU_EN
  assign psum_c = acc_nxt[ACC_W-1] ? '0 : acc_nxt;
`else
  assign psum_c = acc_nxt;
`endif

  // S3: group accumulation and write-back; psum_out survives flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      psum_out <= '0;
      wb_en    <= 1'b0;
    end else if (flush) begin
      acc   <= '0;
      wb_en <= 1'b0;
    end else begin
      wb_en <= v2 && l2;
      if (v2) begin
        acc <= acc_nxt;
        if (l2) begin
          psum_out <= psum_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    finish_wb = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!in_valid && !v1 && !v2 && !open_grp) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        finish_wb = 1'b1;
        state_nxt = in_valid ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

endmodule
